// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: prescaled digit scan, per-frame input snapshot,
// registered active-low outputs. Define SEVSEG_LZ_BLANK_EN to blank leading zeros.
module sevenseg_scan_driver #(
  parameter int REFRESH_BITS = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic       enable,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY,
  output logic       frame_tick
);

  typedef enum logic [1:0] {S0, S1, S2, S3} scan_state_t;

  localparam logic [REFRESH_BITS-1:0] PRESC_ONE = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0] r_presc;
  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic                    w_tick;
  logic                    w_snap;
  logic [3:0]              r_sh0, r_sh1, r_sh2, r_sh3;
  logic                    r_sh_en;
  logic                    r_frame_tick;
  logic [3:0]              r_digit;
  logic [6:0]              r_display;
  logic [3:0]              w_val;
  logic [3:0]              w_digit;
  logic [6:0]              w_seg;
  logic                    w_blank;

  assign w_tick     = &r_presc;
  assign w_snap     = w_tick && (r_state == S3);
  assign DIGIT      = r_digit;
  assign DISPLAY    = r_display;
  assign frame_tick = r_frame_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_presc <= '0;
    else       r_presc <= r_presc + PRESC_ONE;
  end

  // Reset parks the scan in S3 so the first tick both enters S0 and takes a snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S3;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        S0:      w_state_nxt = S1;
        S1:      w_state_nxt = S2;
        S2:      w_state_nxt = S3;
        default: w_state_nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh0        <= '0;
      r_sh1        <= '0;
      r_sh2        <= '0;
      r_sh3        <= '0;
      r_sh_en      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_snap;
      if (w_snap) begin
        r_sh0   <= bcd0;
        r_sh1   <= bcd1;
        r_sh2   <= bcd2;
        r_sh3   <= bcd3;
        r_sh_en <= enable;
      end
    end
  end

  always_comb begin
    w_val   = r_sh0;
    w_digit = 4'b1110;
    case (r_state)
      S0:      begin w_val = r_sh0; w_digit = 4'b1110; end
      S1:      begin w_val = r_sh1; w_digit = 4'b1101; end
      S2:      begin w_val = r_sh2; w_digit = 4'b1011; end
      default: begin w_val = r_sh3; w_digit = 4'b0111; end
    endcase

    case (w_val)
      4'd0:    w_seg = 7'b0000001;
      4'd1:    w_seg = 7'b1001111;
      4'd2:    w_seg = 7'b0010010;
      4'd3:    w_seg = 7'b0000110;
      4'd4:    w_seg = 7'b1001100;
      4'd5:    w_seg = 7'b0100100;
      4'd6:    w_seg = 7'b0100000;
      4'd7:    w_seg = 7'b0001111;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0000100;
      default: w_seg = 7'b1111110;
    endcase

    w_blank = !r_sh_en;
`ifdef SEVSEG_LZ_BLANK_EN
    // Leading zeros are judged on the snapshot, never on the live inputs.
    case (r_state)
      S3:      w_blank = w_blank || (r_sh3 == 4'd0);
      S2:      w_blank = w_blank || (r_sh3 == 4'd0 && r_sh2 == 4'd0);
      S1:      w_blank = w_blank || (r_sh3 == 4'd0 && r_sh2 == 4'd0 && r_sh1 == 4'd0);
      default: w_blank = w_blank;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit   <= 4'b1111;
      r_display <= 7'b1111111;
    end else if (w_blank) begin
      r_digit   <= 4'b1111;
      r_display <= 7'b1111111;
    end else begin
      r_digit   <= w_digit;
      r_display <= w_seg;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with a 4-cycle slot: stimulus pushes per-frame slot
// expectations, a monitor pops and compares them each slot, aligned to frame_tick.
module tb_sevenseg_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       enable;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;
  logic       frame_tick;

  logic [10:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  logic        stim_done;

  localparam logic [10:0] BLANK = {4'b1111, 7'b1111111};

  sevenseg_scan_driver #(.REFRESH_BITS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .enable     (enable),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_slot(input int s, input logic [15:0] b, input logic en);
    logic [3:0] v;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       blank;
    v = b[s*4 +: 4];
    case (s)
      0:       dig = 4'b1110;
      1:       dig = 4'b1101;
      2:       dig = 4'b1011;
      default: dig = 4'b0111;
    endcase
    case (v)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111110;
    endcase
    blank = !en;
`ifdef SEVSEG_LZ_BLANK_EN
    if (s == 3 && b[15:12] == 4'd0) blank = 1'b1;
    if (s == 2 && b[15:8] == 8'd0)  blank = 1'b1;
    if (s == 1 && b[15:4] == 12'd0) blank = 1'b1;
`endif
    return blank ? BLANK : {dig, seg};
  endfunction

  // driver tasks
  task automatic drive(input logic [15:0] b, input logic en);
    bcd3   = b[15:12];
    bcd2   = b[11:8];
    bcd1   = b[7:4];
    bcd0   = b[3:0];
    enable = en;
  endtask

  task automatic push_frame(input logic [15:0] b, input logic en);
    for (int s = 0; s < 4; s++) exp_q.push_back(exp_slot(s, b, en));
  endtask

  // Waits for a snapshot, then after 'dly' more negedges drives the next frame's inputs.
  task automatic frame_next(input logic [15:0] b, input logic en, input int dly);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    if (!frame_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL stim_frame_wait: got no frame_tick expected one within 40 clk");
    end
    repeat (dly) @(negedge clk);
    drive(b, en);
    push_frame(b, en);
  endtask

  // scoreboard monitor: started at a reset-release negedge
  task automatic run_monitor();
    int          n;
    logic [10:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!frame_tick) check("pre_frame_blank", {DIGIT, DISPLAY}, BLANK);
    end while (!frame_tick && n < 40);
    check("first_snapshot_latency", 11'(n), 11'd4);
    while (1) begin
      #1;
      if (stim_done && exp_q.size() == 0) break;
      if (exp_q.size() < 4) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got %0d entries expected 4", exp_q.size());
        break;
      end
      for (int s = 0; s < 4; s++) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("slot%0d_cyc%0d", s, k), {DIGIT, DISPLAY}, e);
          check($sformatf("frame_tick_s%0d_c%0d", s, k), 11'(frame_tick),
                11'((s == 3 && k == 3) ? 1 : 0));
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    stim_done = 1'b0;
    reset     = 1'b1;
    drive(16'h3210, 1'b1);
    repeat (2) @(negedge clk);
    check("reset_outputs", {DIGIT, DISPLAY}, BLANK);
    check("reset_frame_tick", 11'(frame_tick), 11'd0);
    push_frame(16'h3210, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    fork
      run_monitor();
      begin
        frame_next(16'h3217, 1'b1, 2);   // bcd0 change mid-frame
        frame_next(16'h3C17, 1'b1, 0);   // code 12 shows a dash
        frame_next(16'h9C86, 1'b1, 3);
        frame_next(16'h54B2, 1'b1, 7);
        frame_next(16'h8888, 1'b0, 1);   // display disabled
        frame_next(16'h0005, 1'b1, 15);  // enable rises on the snapshot edge
        frame_next(16'h0000, 1'b1, 0);
        frame_next(16'h0100, 1'b1, 5);
        stim_done = 1'b1;
      end
    join

    // Reset asserted inside the digit2 slot.
    repeat (10) @(negedge clk);
    check("pre_reset_digit2", {DIGIT, DISPLAY}, exp_slot(2, 16'h0100, 1'b1));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {DIGIT, DISPLAY}, BLANK);
    check("async_reset_frame_tick", 11'(frame_tick), 11'd0);
    drive(16'h3210, 1'b1);
    push_frame(16'h3210, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    run_monitor();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
